idu_pipe: RTL and testbench
===========================

Name: idu_pipe

Overview:
Registered RV32I/M instruction decode stage with valid/ready handshakes on both sides and a 2-entry skid buffer. It accepts a 32-bit instruction word plus PC from fetch and emits an instruction-class index (opc). It also emits register indices, a sign-extended immediate and an illegal-instruction flag. It sits between the IFU and EXU, adds one cycle of latency at full throughput, and supports pipeline flush.

Parameters:
XLEN, 32, datapath width; imm and pc are sign-extended or passed at this width.
NR_INST, 46, number of decodable instruction classes.
OPC_WIDTH, $clog2(NR_INST+1) = 6, width of opc.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  discard all buffered instructions
in_valid  in  1  upstream instruction valid
in_ready  out  1  stage can accept
in_inst  in  32  instruction word
in_pc  in  XLEN  instruction address
out_valid  out  1  decoded instruction valid
out_ready  in  1  downstream accepts
out_opc  out  OPC_WIDTH  class index; 0 = illegal
out_rd  out  5  inst[11:7]
out_rs1  out  5  inst[19:15]
out_rs2  out  5  inst[24:20]
out_imm  out  XLEN  sign-extended immediate
out_pc  out  XLEN  pc passthrough
out_illegal  out  1  undecodable instruction

Behaviour:
- Reset (async, rst=1): out_valid=0, skid_valid=0, in_ready=1, out_opc/rd/rs1/rs2/imm/pc=0, out_illegal=0. Effect is immediate, regardless of clk. Any beat in flight mid-operation is lost.
- Decode is combinational on in_inst. It is captured into the output register, or into the skid register when the output register is held.
- opc numbering is fixed:
  - 1-10: add, sub, xor, or, and, sll, srl, sra, slt, sltu.
  - 11-19: addi, xori, ori, andi, slli, srli, srai, slti, sltiu.
  - 20-24: lb, lh, lw, lbu, lhu.
  - 25-27: sb, sh, sw.
  - 28-33: beq, bne, blt, bge, bltu, bgeu.
  - 34-37: jal, jalr, lui, auipc.
  - 38: ecall/ebreak.
  - 39-46: mul, mulh, mulhsu, mulhu, div, divu, rem, remu.
- Illegal (opc=0, out_illegal=1) when any of the following holds:
  - inst[1:0] != 2'b11;
  - the opcode/funct3/funct7 combination is not listed;
  - shift-immediate funct7 is not 0x00/0x20 (srai only 0x20, slli only 0x00);
  - a SYSTEM encoding is not exactly 0x00000073 or 0x00100073.
- Immediate by format, sign-extended from bit 31 to XLEN:
  - I: inst[31:20]; shifts give zero-extended shamt inst[24:20].
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U: {inst[31:12], 12'b0}.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - R-type and illegal: 0.
- rd/rs1/rs2 are always raw fields. Consumers ignore them per class.
- Handshake:
  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
  - in_ready is registered: in_ready = !skid_valid.
  - Payloads are held stable while out_valid & !out_ready.
- Per-cycle actions (1-cycle latency, in_fire at edge N gives out_valid at N+1):
  - in_fire with (out empty or out_fire) and skid empty: load output register.
  - in_fire while output held (out_valid & !out_ready): load skid; in_ready drops next cycle.
  - out_fire with skid valid: skid moves to output; skid clears; in_ready rises next cycle.
  - out_fire with skid empty and no in_fire: out_valid=0 next cycle.
- Order is strictly preserved. No beat is duplicated or dropped except by flush or rst.
- Flush (sync): next edge clears out_valid and skid_valid and sets in_ready=1. An in_fire coinciding with flush is discarded. Flush dominates all other events.

Optional Feature:
IDU_MEXT_EN: when defined, opc 39-46 (M extension) decode as listed. When undefined, any funct7=0x01 R-type decodes as illegal (opc=0, out_illegal=1) and the M-decode logic is not synthesised. opc numbering is unchanged either way.

Test Plan:
- Reset then in_inst=0x002081B3 (add x3,x1,x2), out_ready=1 -> one cycle later out_opc=1, rd=3, rs1=1, rs2=2, imm=0, illegal=0.
- 0xFFF00093 (addi x1,x0,-1) -> opc=11, imm=0xFFFFFFFF. 0xFE000EE3 (beq x0,x0,-4) -> opc=28, imm=0xFFFFFFFC.
- 0x027302B3 (mul x5,x6,x7): with IDU_MEXT_EN -> opc=39. Without it -> opc=0, illegal=1. Also 0x00000000 -> opc=0, illegal=1.
- out_ready=0, three back-to-back beats A,B,C -> A held at output, B in skid, in_ready=0 and C not accepted. Raise out_ready -> A, B, C emerge in order on consecutive cycles.
- Output and skid full, pulse flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, no beat emerges afterward.
- Assert rst asynchronously mid-stream between clock edges -> out_valid=0 and in_ready=1 immediately.

Source files
------------

// File: rtl/idu_pipe.sv
// idu_pipe: registered RV32I/M decode stage with an output register plus one skid entry.
// Compile with IDU_MEXT_EN defined to decode the M extension (opc 39-46).
module idu_pipe #(
    parameter int XLEN      = 32,
    parameter int NR_INST   = 46,
    parameter int OPC_WIDTH = $clog2(NR_INST + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_inst,
    input  logic [XLEN-1:0]      in_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OPC_WIDTH-1:0] out_opc,
    output logic [4:0]           out_rd,
    output logic [4:0]           out_rs1,
    output logic [4:0]           out_rs2,
    output logic [XLEN-1:0]      out_imm,
    output logic [XLEN-1:0]      out_pc,
    output logic                 out_illegal
);

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J
    } fmt_e;

    typedef struct packed {
        logic [OPC_WIDTH-1:0] opc;
        logic [4:0]           rd;
        logic [4:0]           rs1;
        logic [4:0]           rs2;
        logic [XLEN-1:0]      imm;
        logic [XLEN-1:0]      pc;
        logic                 illegal;
    } beat_t;

    function automatic logic [OPC_WIDTH-1:0] op(input int n);
        return OPC_WIDTH'(n);
    endfunction

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;

    assign opcode = in_inst[6:0];
    assign f3     = in_inst[14:12];
    assign f7     = in_inst[31:25];

    logic signed [11:0] imm_i12;
    logic signed [11:0] imm_s12;
    logic signed [12:0] imm_b13;
    logic signed [31:0] imm_u32;
    logic signed [20:0] imm_j21;

    assign imm_i12 = in_inst[31:20];
    assign imm_s12 = {in_inst[31:25], in_inst[11:7]};
    assign imm_b13 = {in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign imm_u32 = {in_inst[31:12], 12'b0};
    assign imm_j21 = {in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

    logic [OPC_WIDTH-1:0] dec_opc;
    fmt_e                 dec_fmt;
    logic                 dec_illegal;
    logic [XLEN-1:0]      dec_imm;
    beat_t                dec_beat;

    // Class lookup: any encoding not matched below leaves opc at 0 (illegal).
    always_comb begin
        dec_opc = '0;
        dec_fmt = FMT_R;
        case (opcode)
            7'b0110011: begin
                dec_fmt = FMT_R;
                if (f7 == 7'h00) begin
                    case (f3)
                        3'd0: dec_opc = op(1);
                        3'd1: dec_opc = op(6);
                        3'd2: dec_opc = op(9);
                        3'd3: dec_opc = op(10);
                        3'd4: dec_opc = op(3);
                        3'd5: dec_opc = op(7);
                        3'd6: dec_opc = op(4);
                        default: dec_opc = op(5);
                    endcase
                end else if (f7 == 7'h20) begin
                    if (f3 == 3'd0)      dec_opc = op(2);
                    else if (f3 == 3'd5) dec_opc = op(8);
                end
`ifdef IDU_MEXT_EN
                else if (f7 == 7'h01) begin
                    dec_opc = op(39) + OPC_WIDTH'(f3);
                end
`else
                else begin
                    dec_opc = '0;
                end
`endif
            end
            7'b0010011: begin
                dec_fmt = FMT_I;
                case (f3)
                    3'd0: dec_opc = op(11);
                    3'd4: dec_opc = op(12);
                    3'd6: dec_opc = op(13);
                    3'd7: dec_opc = op(14);
                    3'd2: dec_opc = op(18);
                    3'd3: dec_opc = op(19);
                    3'd1: begin
                        dec_fmt = FMT_SH;
                        if (f7 == 7'h00) dec_opc = op(15);
                    end
                    default: begin
                        dec_fmt = FMT_SH;
                        if (f7 == 7'h00)      dec_opc = op(16);
                        else if (f7 == 7'h20) dec_opc = op(17);
                    end
                endcase
            end
            7'b0000011: begin
                dec_fmt = FMT_I;
                case (f3)
                    3'd0:    dec_opc = op(20);
                    3'd1:    dec_opc = op(21);
                    3'd2:    dec_opc = op(22);
                    3'd4:    dec_opc = op(23);
                    3'd5:    dec_opc = op(24);
                    default: dec_opc = '0;
                endcase
            end
            7'b0100011: begin
                dec_fmt = FMT_S;
                case (f3)
                    3'd0:    dec_opc = op(25);
                    3'd1:    dec_opc = op(26);
                    3'd2:    dec_opc = op(27);
                    default: dec_opc = '0;
                endcase
            end
            7'b1100011: begin
                dec_fmt = FMT_B;
                case (f3)
                    3'd0:    dec_opc = op(28);
                    3'd1:    dec_opc = op(29);
                    3'd4:    dec_opc = op(30);
                    3'd5:    dec_opc = op(31);
                    3'd6:    dec_opc = op(32);
                    3'd7:    dec_opc = op(33);
                    default: dec_opc = '0;
                endcase
            end
            7'b1101111: begin
                dec_fmt = FMT_J;
                dec_opc = op(34);
            end
            7'b1100111: begin
                dec_fmt = FMT_I;
                if (f3 == 3'd0) dec_opc = op(35);
            end
            7'b0110111: begin
                dec_fmt = FMT_U;
                dec_opc = op(36);
            end
            7'b0010111: begin
                dec_fmt = FMT_U;
                dec_opc = op(37);
            end
            7'b1110011: begin
                dec_fmt = FMT_I;
                if (in_inst == 32'h0000_0073 || in_inst == 32'h0010_0073) dec_opc = op(38);
            end
            default: begin
                dec_opc = '0;
                dec_fmt = FMT_R;
            end
        endcase
    end

    assign dec_illegal = (dec_opc == '0);

    always_comb begin
        dec_imm = '0;
        if (!dec_illegal) begin
            case (dec_fmt)
                FMT_I:   dec_imm = XLEN'(imm_i12);
                FMT_SH:  dec_imm = XLEN'(in_inst[24:20]);
                FMT_S:   dec_imm = XLEN'(imm_s12);
                FMT_B:   dec_imm = XLEN'(imm_b13);
                FMT_U:   dec_imm = XLEN'(imm_u32);
                FMT_J:   dec_imm = XLEN'(imm_j21);
                default: dec_imm = '0;
            endcase
        end
    end

    always_comb begin
        dec_beat.opc     = dec_opc;
        dec_beat.rd      = in_inst[11:7];
        dec_beat.rs1     = in_inst[19:15];
        dec_beat.rs2     = in_inst[24:20];
        dec_beat.imm     = dec_imm;
        dec_beat.pc      = in_pc;
        dec_beat.illegal = dec_illegal;
    end

    // Output register + skid entry; in_ready is low exactly while the skid holds a beat.
    logic  out_valid_q, out_valid_d;
    logic  skid_valid_q, skid_valid_d;
    beat_t out_q, out_d;
    beat_t skid_q, skid_d;
    logic  in_fire;
    logic  out_held;

    assign in_ready = ~skid_valid_q;
    assign in_fire  = in_valid & in_ready;
    assign out_held = out_valid_q & ~out_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        out_d        = out_q;
        skid_d       = skid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_held) begin
            if (in_fire) begin
                skid_d       = dec_beat;
                skid_valid_d = 1'b1;
            end
        end else if (skid_valid_q) begin
            out_d        = skid_q;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
        end else if (in_fire) begin
            out_d       = dec_beat;
            out_valid_d = 1'b1;
        end else begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_q        <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            out_q        <= out_d;
        end
    end

    // Skid payload is only observed through skid_valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        skid_q <= skid_d;
    end

    assign out_valid   = out_valid_q;
    assign out_opc     = out_q.opc;
    assign out_rd      = out_q.rd;
    assign out_rs1     = out_q.rs1;
    assign out_rs2     = out_q.rs2;
    assign out_imm     = out_q.imm;
    assign out_pc      = out_q.pc;
    assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_idu_pipe.sv
// tb_idu_pipe: directed and randomized checks of idu_pipe against a mask/match table decoder
// and an occupancy-queue model of the two-entry buffer.
module tb_idu_pipe;
    localparam int XLEN = 32;
    localparam int OPCW = 6;

    logic            clk = 1'b0;
    logic            rst, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc, out_imm, out_pc;
    logic [OPCW-1:0] out_opc;
    logic [4:0]      out_rd, out_rs1, out_rs2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    idu_pipe dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_opc(out_opc),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_imm(out_imm), .out_pc(out_pc), .out_illegal(out_illegal)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference decoder: first matching (mask, match) entry gives class and immediate format.
    localparam int F_R = 0, F_I = 1, F_SH = 2, F_S = 3, F_B = 4, F_U = 5, F_J = 6;
    typedef struct { logic [31:0] mask; logic [31:0] match; int opc; int fmt; } pat_t;
    pat_t pats[$];

    typedef struct packed {
        logic [5:0]  opc;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm, pc;
        logic        ill;
    } beat_t;

    function automatic void add_pat(input logic [31:0] mask, input int f7, input int f3,
                                    input int opcode, input int opc, input int fmt);
        pat_t p;
        p.mask  = mask;
        p.match = (32'(f7) << 25) | (32'(f3) << 12) | 32'(opcode);
        p.opc   = opc;
        p.fmt   = fmt;
        pats.push_back(p);
    endfunction

    function automatic void build_pats();
        int ld_f3[5] = '{0, 1, 2, 4, 5};
        int br_f3[6] = '{0, 1, 4, 5, 6, 7};
        int op_f3[10] = '{0, 0, 4, 6, 7, 1, 5, 5, 2, 3};
        int op_f7[10] = '{0, 32, 0, 0, 0, 0, 0, 32, 0, 0};
        int im_f3[9] = '{0, 4, 6, 7, 1, 5, 5, 2, 3};
        int im_f7[9] = '{0, 0, 0, 0, 0, 0, 32, 0, 0};
        for (int i = 0; i < 10; i++) add_pat(32'hFE00707F, op_f7[i], op_f3[i], 'h33, 1 + i, F_R);
        for (int i = 0; i < 9; i++) begin
            if (im_f3[i] == 1 || im_f3[i] == 5)
                add_pat(32'hFE00707F, im_f7[i], im_f3[i], 'h13, 11 + i, F_SH);
            else
                add_pat(32'h0000707F, 0, im_f3[i], 'h13, 11 + i, F_I);
        end
        for (int i = 0; i < 5; i++) add_pat(32'h0000707F, 0, ld_f3[i], 'h03, 20 + i, F_I);
        for (int i = 0; i < 3; i++) add_pat(32'h0000707F, 0, i, 'h23, 25 + i, F_S);
        for (int i = 0; i < 6; i++) add_pat(32'h0000707F, 0, br_f3[i], 'h63, 28 + i, F_B);
        add_pat(32'h0000007F, 0, 0, 'h6F, 34, F_J);
        add_pat(32'h0000707F, 0, 0, 'h67, 35, F_I);
        add_pat(32'h0000007F, 0, 0, 'h37, 36, F_U);
        add_pat(32'h0000007F, 0, 0, 'h17, 37, F_U);
        add_pat(32'hFFFFFFFF, 0, 0, 'h73, 38, F_I);
        add_pat(32'hFFFFFFFF, 0, 0, 'h00100073, 38, F_I);
`ifdef IDU_MEXT_EN
        for (int i = 0; i < 8; i++) add_pat(32'hFE00707F, 1, i, 'h33, 39 + i, F_R);
`endif
    endfunction

    function automatic beat_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
        beat_t b;
        int    hit;
        b.opc = '0; b.imm = '0; b.pc = pc;
        b.rd = w[11:7]; b.rs1 = w[19:15]; b.rs2 = w[24:20];
        hit = -1;
        foreach (pats[k]) if (hit < 0 && (w & pats[k].mask) == pats[k].match) hit = k;
        if (hit >= 0) begin
            b.opc = 6'(pats[hit].opc);
            case (pats[hit].fmt)
                F_I:  b.imm = {{20{w[31]}}, w[31:20]};
                F_SH: b.imm = {27'b0, w[24:20]};
                F_S:  b.imm = {{20{w[31]}}, w[31:25], w[11:7]};
                F_B:  b.imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
                F_U:  b.imm = {w[31:12], 12'b0};
                F_J:  b.imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
                default: b.imm = '0;
            endcase
        end
        b.ill = (b.opc == 6'd0);
        return b;
    endfunction

    // Scoreboard: queue holds beats accepted but not yet delivered (0..2).
    beat_t exp_q[$];
    beat_t mon_e;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            check("out_valid", out_valid, exp_q.size() > 0);
            check("in_ready", in_ready, exp_q.size() < 2);
            if (flush) begin
                exp_q.delete();
            end else begin
                if (out_valid && out_ready && exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("opc", out_opc, mon_e.opc);
                    check("rd", out_rd, mon_e.rd);
                    check("rs1", out_rs1, mon_e.rs1);
                    check("rs2", out_rs2, mon_e.rs2);
                    check("imm", out_imm, mon_e.imm);
                    check("pc", out_pc, mon_e.pc);
                    check("illegal", out_illegal, mon_e.ill);
                end
                if (in_valid && in_ready) exp_q.push_back(ref_decode(in_inst, in_pc));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w, input logic [31:0] pc);
        in_valid = 1'b1; in_inst = w; in_pc = pc;
        step();
        in_valid = 1'b0;
    endtask

    int r, k;
    logic [31:0] w;

    initial begin
        build_pats();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_inst = '0; in_pc = '0;
        step(); step();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_opc", out_opc, 0);
        check("rst_imm", out_imm, 0);
        check("rst_pc", out_pc, 0);
        check("rst_rd", out_rd, 0);
        check("rst_illegal", out_illegal, 0);
        rst = 1'b0; out_ready = 1'b1;

        send(32'h002081B3, 32'h100);
        check("add_valid", out_valid, 1);
        check("add_opc", out_opc, 1);
        check("add_rd", out_rd, 3);
        check("add_rs1", out_rs1, 1);
        check("add_rs2", out_rs2, 2);
        check("add_imm", out_imm, 0);
        check("add_pc", out_pc, 32'h100);
        check("add_illegal", out_illegal, 0);
        send(32'hFFF00093, 32'h104);
        check("addi_opc", out_opc, 11);
        check("addi_imm", out_imm, 32'hFFFFFFFF);
        send(32'hFE000EE3, 32'h108);
        check("beq_opc", out_opc, 28);
        check("beq_imm", out_imm, 32'hFFFFFFFC);
        send(32'h027302B3, 32'h10C);
`ifdef IDU_MEXT_EN
        check("mul_opc", out_opc, 39);
        check("mul_illegal", out_illegal, 0);
`else
        check("mul_opc", out_opc, 0);
        check("mul_illegal", out_illegal, 1);
`endif
        send(32'h00000000, 32'h110);
        check("zero_opc", out_opc, 0);
        check("zero_illegal", out_illegal, 1);
        check("zero_imm", out_imm, 0);
        step();

        // Backpressure: A held, B in skid, C refused until the output drains.
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h002081B3; in_pc = 32'h200; step();
        in_inst = 32'h40000033; in_pc = 32'h204; step();
        in_inst = 32'h003140B3; in_pc = 32'h208; step();
        check("bp_in_ready", in_ready, 0);
        check("bp_hold_opc", out_opc, 1);
        check("bp_hold_pc", out_pc, 32'h200);
        out_ready = 1'b1; step();
        check("bp_b_opc", out_opc, 2);
        check("bp_b_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        check("bp_c_opc", out_opc, 3);
        check("bp_c_pc", out_pc, 32'h208);
        step();
        check("bp_empty", out_valid, 0);

        // Flush with both entries full and an incoming beat.
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h002081B3; in_pc = 32'h300; step();
        in_inst = 32'hFFF00093; in_pc = 32'h304; step();
        check("fl_full", in_ready, 0);
        flush = 1'b1; in_inst = 32'hFE000EE3; in_pc = 32'h308; step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_valid", out_valid, 0);
        check("fl_ready", in_ready, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("fl_drain", out_valid, 0);
        end

        // Asynchronous reset between clock edges.
        out_ready = 1'b0;
        send(32'h002081B3, 32'h400);
        send(32'h40000033, 32'h404);
        check("ar_full", in_ready, 0);
        #2 rst = 1'b1;
        #1;
        check("ar_valid", out_valid, 0);
        check("ar_ready", in_ready, 1);
        check("ar_opc", out_opc, 0);
        step();
        rst = 1'b0;

        for (int n = 0; n < 2000; n++) begin
            r = $urandom_range(0, 9);
            k = $urandom_range(0, pats.size() - 1);
            if (r < 6) w = ($urandom & ~pats[k].mask) | pats[k].match;
            else if (r < 8) begin w = $urandom; w[6:0] = pats[k].match[6:0]; end
            else w = $urandom;
            in_inst   = w;
            in_pc     = $urandom;
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 49) == 0);
            step();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (4) step();
        check("drain_queue", exp_q.size(), 0);
        check("drain_valid", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
